// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore, except the jr PC update in R_EXEC).
// Optional feature: define MC_JAL_EN to support the jal instruction (opcode 000011).
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       JRsel,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ZeroExt,
    output logic       IllegalOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [2:0] ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t state_q, state_d;
    logic [2:0] iop;
    logic       izx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ALU controls shared by I_EXEC and I_WB so the result is held through write-back
    always_comb begin
        iop = 3'b110;
        izx = 1'b0;
        case (Opcode)
            OP_ANDI: begin iop = 3'b001; izx = 1'b1; end
            OP_ORI:  begin iop = 3'b101; izx = 1'b1; end
            OP_LUI:  iop = 3'b100;
            default: iop = 3'b110;
        endcase
    end

    always_comb begin
        state_d     = IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ZeroExt     = 1'b0;
        IllegalOp   = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUOp       = 3'b000;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b110;
                PCWrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b110;
                case (Opcode)
                    OP_LW, OP_SW:                     state_d = MEM_ADDR;
                    OP_R:                             state_d = R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = I_EXEC;
                    OP_BEQ, OP_BNE:                   state_d = BRANCH;
                    OP_J:                             state_d = JUMP;
`ifdef MC_JAL_EN
                    OP_JAL:                           state_d = JAL;
`endif
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (Opcode == OP_LW) ? 3'b011 : 3'b010;
                state_d = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = FETCH;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                if (JRsel) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    state_d  = FETCH;
                end else begin
                    state_d  = R_WB;
                end
            end
            R_WB: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b111;
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                state_d  = FETCH;
            end
            I_EXEC, I_WB: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = iop;
                ZeroExt  = izx;
                RegWrite = (state_q == I_WB);
                state_d  = (state_q == I_WB) ? FETCH : I_WB;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (Opcode == OP_BNE);
                state_d     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = FETCH;
            end
`ifdef MC_JAL_EN
            JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                state_d  = FETCH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream vs. per-instruction cycle model.
// Honors MC_JAL_EN the same way as the design.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bne, iord, mr, mw, irw, rw, asa, zx, ill;
        logic [1:0] asb, pcs, rd, m2r;
        logic [2:0] aop;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       JRsel = 1'b0;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, ALUSrcA, ZeroExt, IllegalOp;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;
    logic [2:0] ALUOp;
    logic [3:0] State;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .JRsel(JRsel),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ZeroExt(ZeroExt), .IllegalOp(IllegalOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .State(State)
    );

    always #5 clk = ~clk;

    rec_t act;
    assign act = '{State, PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                   RegWrite, ALUSrcA, ZeroExt, IllegalOp, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp};

`ifdef MC_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   active  = 1'b0;
    rec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
        end
    endtask

    function automatic rec_t z(input logic [3:0] st);
        rec_t r = '0;
        r.st = st;
        return r;
    endfunction

    // Expected per-cycle outputs of one whole instruction, FETCH through its last state.
    function automatic int model(input logic [5:0] op, input logic jr);
        rec_t r;
        int   n = 2;
        bit   legal;
        legal = (op inside {6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
                            6'b001101, 6'b001111, 6'b100011, 6'b101011}) || (JAL_EN && op == 6'b000011);
        r = z(1); r.mr = 1; r.irw = 1; r.asb = 2'b01; r.aop = 3'b110; r.pcw = 1;
        exp_q.push_back(r);
        r = z(2); r.asb = 2'b11; r.aop = 3'b110; r.ill = !legal;
        exp_q.push_back(r);
        if (!legal) return n;
        case (op)
            6'b100011, 6'b101011: begin
                r = z(3); r.asa = 1; r.asb = 2'b10; r.aop = (op == 6'b100011) ? 3'b011 : 3'b010;
                exp_q.push_back(r);
                if (op == 6'b100011) begin
                    r = z(4); r.mr = 1; r.iord = 1; exp_q.push_back(r);
                    r = z(5); r.rw = 1; r.m2r = 2'b01; exp_q.push_back(r);
                    n += 3;
                end else begin
                    r = z(6); r.mw = 1; r.iord = 1; exp_q.push_back(r);
                    n += 2;
                end
            end
            6'b000000: begin
                r = z(7); r.asa = 1; r.aop = 3'b111;
                if (jr) begin r.pcw = 1; r.pcs = 2'b11; end
                exp_q.push_back(r);
                n += 1;
                if (!jr) begin
                    r = z(8); r.asa = 1; r.aop = 3'b111; r.rw = 1; r.rd = 2'b01;
                    exp_q.push_back(r);
                    n += 1;
                end
            end
            6'b000100, 6'b000101: begin
                r = z(11); r.asa = 1; r.pcwc = 1; r.pcs = 2'b01; r.bne = (op == 6'b000101);
                exp_q.push_back(r);
                n += 1;
            end
            6'b000010: begin
                r = z(12); r.pcw = 1; r.pcs = 2'b10; exp_q.push_back(r);
                n += 1;
            end
            6'b000011: begin
                r = z(13); r.pcw = 1; r.pcs = 2'b10; r.rw = 1; r.rd = 2'b10; r.m2r = 2'b10;
                exp_q.push_back(r);
                n += 1;
            end
            default: begin
                r = z(9); r.asa = 1; r.asb = 2'b10;
                r.aop = (op == 6'b001100) ? 3'b001 : (op == 6'b001101) ? 3'b101 :
                        (op == 6'b001111) ? 3'b100 : 3'b110;
                r.zx = (op == 6'b001100) || (op == 6'b001101);
                exp_q.push_back(r);
                r.st = 4'd10; r.rw = 1;
                exp_q.push_back(r);
                n += 2;
            end
        endcase
        return n;
    endfunction

    always @(negedge clk) begin
        if (active) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underrun", 32'd0, 32'd1);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk($sformatf("cycle_state%0d", e.st), 32'(act), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] legal_ops [11] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                                   6'b001000, 6'b001100, 6'b001101, 6'b001111, 6'b100011, 6'b101011};

    initial begin
        int len;
        logic [5:0] op;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 32'(act), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back(z(0));
        active = 1'b1;

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 10)];
            else                          op = 6'($urandom);
            if (i == 0) op = 6'b111111;
            Opcode = op;
            JRsel  = 1'($urandom);
            len = model(op, JRsel);
            repeat (len - 1) @(posedge clk);
        end

        // async reset landing in MEM_READ of a load
        @(posedge clk); #1;
        active = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        Opcode = 6'b100011;
        JRsel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_lw_state", 32'(State), 32'd4);
        chk("mid_lw_memread", 32'(MemRead), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(act), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_regwrite", 32'(RegWrite), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        chk("release_idle", 32'(act), 32'd0);
        @(posedge clk); #1;
        chk("release_fetch_state", 32'(State), 32'd1);
        chk("release_fetch_ctl", 32'({MemRead, IRWrite, PCWrite, ALUOp}), 32'({3'b111, 3'b110}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main control FSM for the multicycle MIPS datapath, sitting directly upstream of the ALU control unit. It decodes the 6-bit opcode held in the instruction register and sequences the instruction through fetch, decode, execute, memory and write-back. Each state drives the datapath enables, mux selects and the 3-bit ALUOp consumed by the ALU control unit. JRsel from the ALU control unit is fed back so that `jr` completes in the execute state.

## Interface
Parameters:
- none. State encoding is fixed: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, JAL=13.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26]; stable from DECODE until next FETCH.
- JRsel  in  1  from ALU control unit; high when the R-type funct is `jr`.
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt, IllegalOp  out  1 each.
- ALUSrcB, PCSource, RegDst, MemtoReg  out  2 each.
- ALUOp  out  3  to ALU control unit: R=111, ADDI=110, ORI=101, LUI=100, LW=011, SW=010, ANDI=001, BEQ/BNE=000.
- State  out  4  current state, for debug/verification.

## Operation
Supported opcodes:
- R=000000, J=000010, JAL=000011, BEQ=000100, BNE=000101, ADDI=001000, ANDI=001100, ORI=001101, LUI=001111, LW=100011, SW=101011.

Default output value: every output not listed for a state is 0.

States and transitions:
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=110, PCSource=00, PCWrite=1. Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=110 (branch target). Next state by opcode:
  - LW/SW → MEM_ADDR; R → R_EXEC; ADDI/ANDI/ORI/LUI → I_EXEC; BEQ/BNE → BRANCH; J → JUMP; JAL → JAL.
  - Any other opcode: IllegalOp=1 for this cycle, next state FETCH. The instruction becomes a no-op.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=011 (LW) or 010 (SW). LW → MEM_READ; SW → MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Goes to MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111.
  - JRsel=1: PCWrite=1, PCSource=11 (these two are Mealy on JRsel); next FETCH.
  - JRsel=0: next R_WB.
- R_WB: ALUSrcA=1, ALUSrcB=00, ALUOp=111 held, RegWrite=1, RegDst=01, MemtoReg=00. Goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode; ZeroExt=1 for ANDI/ORI. Goes to I_WB.
- I_WB: same ALU controls as I_EXEC held, RegWrite=1, RegDst=00, MemtoReg=00. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCWriteCond=1, PCSource=01; BranchNE=1 for BNE. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10 ($31), MemtoReg=10 (PC). Goes to FETCH.
- Any unused state encoding (14, 15): next state IDLE, all outputs 0.

## Timing
- Outputs are combinational from the state register plus Opcode/JRsel; no output registers.
- Reset asserted at any time, including mid-instruction: state forced to IDLE asynchronously and all outputs go to 0 immediately. After reset release: IDLE for one cycle, then FETCH.
- Cycles per instruction: LW 5; SW, R-type, I-type 4; JR, BEQ/BNE, J, JAL 3; illegal opcode 2.
- JRsel is sampled only in R_EXEC. Opcode is sampled only in DECODE, MEM_ADDR, I_EXEC, I_WB and BRANCH.

## Configuration
- MC_JAL_EN defined: JAL opcode 000011 goes to the JAL state as specified above.
- MC_JAL_EN undefined:
  - JAL state and its logic are removed.
  - Opcode 000011 is illegal: IllegalOp=1 in DECODE, next state FETCH.
  - RegDst and MemtoReg never take the value 10.

## Test plan
- Reset: hold reset=0 → State=0 and all outputs 0. Release → State=1 on the next edge with MemRead=IRWrite=PCWrite=1 and ALUOp=110.
- LW (100011) → State sequence 1,2,3,4,5,1. MEM_ADDR shows ALUOp=011, ALUSrcB=10; MEM_WB shows RegWrite=1, MemtoReg=01.
- R-type with JRsel=0 → states 1,2,7,8,1 with ALUOp=111 in 7 and 8. Same with JRsel=1 → states 1,2,7,1 with PCWrite=1, PCSource=11 in state 7.
- BNE (000101) → BRANCH shows PCWriteCond=1, BranchNE=1, ALUOp=000. ORI (001101) → I_EXEC shows ALUOp=101, ZeroExt=1.
- Opcode 111111 → IllegalOp=1 in DECODE, then FETCH. JAL: with MC_JAL_EN → state 13 with RegDst=10, MemtoReg=10; without it → IllegalOp=1.
- Drive reset=0 during MEM_READ of an LW → State=0 and MemRead=0 within the same cycle, with no RegWrite pulse afterwards.
